key_event_encoder: RTL
======================

Name: key_event_encoder

Overview:
- Parametrised successor to the fixed WASD key encoder.
- Sits after the PS/2 keyboard decoder and maps 9-bit scan codes ({ext, byte}) to key numbers through a runtime-loadable table of N_KEYS entries.
- Tracks which keys are held, generates auto-repeat events and queues press/release/repeat events in a FIFO with a valid/ready output handshake toward game/control logic.

Parameters:
- N_KEYS, 8, number of map-table entries (N_KEYS <= 2**NUM_W).
- NUM_W, 3, width of encoded key number.
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >= 2).
- REPEAT_DELAY, 25000000, cycles from press to first repeat event (>= 2).
- REPEAT_PERIOD, 5000000, cycles between later repeat events (>= 2).
- CNT_W, 25, repeat counter width (must hold max(REPEAT_DELAY, REPEAT_PERIOD)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ev_valid  in  1  single-cycle strobe: new decoder event.
- ev_code  in  9  {extended flag, scan byte}.
- ev_release  in  1  1 = key released, 0 = key pressed.
- rep_en  in  1  auto-repeat enable.
- cfg_we  in  1  map-table write strobe.
- cfg_idx  in  NUM_W  table index to write.
- cfg_code  in  9  scan code for entry; 9'h000 disables the entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head entry when out_valid & out_ready.
- out_kind  out  2  0 = press, 1 = release, 2 = repeat.
- out_num  out  NUM_W  encoded key number.
- key_held  out  N_KEYS  held bit per entry.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (sync, high): outputs are all 0 (out_valid=0, out_kind=0, out_num=0, key_held=0, overflow=0). FIFO is emptied, FSM goes to IDLE, counter=0. Map defaults: entry0=9'h01D (W), 1=9'h01B (S), 2=9'h01C (A), 3=9'h023 (D), others 9'h000. Reset mid-operation discards queued events.
- Lookup is combinational. Match = lowest index i with table[i]==ev_code and table[i]!=0. A code with no match is ignored.
- Press of matched i:
  - If held[i] is already set (keyboard typematic), the event is ignored.
  - Otherwise set held[i], push {press, i}, last_key=i, FSM goes to DELAY with counter=0 (DELAY only if rep_en, else IDLE).
- Release of matched i:
  - If held[i] is clear, the event is ignored.
  - Otherwise clear held[i] and push {release, i}. If i==last_key, FSM goes to IDLE.
- Repeat FSM:
  - IDLE: counter held at 0.
  - DELAY: counter increments each cycle. At REPEAT_DELAY-1, push {repeat, last_key}, go to REPEAT, counter=0.
  - REPEAT: at REPEAT_PERIOD-1, push {repeat, last_key}, counter=0.
  - rep_en=0 forces IDLE in any state.
- Simultaneous input event and repeat expiry: the input event is pushed and the repeat event is dropped. The counter still resets to 0, and the state follows the input-event rules.
- FIFO latency: a push at edge t is visible on out_valid/out_kind/out_num after edge t (first-word-fall-through from registered storage). There is no same-cycle bypass: out_valid=0 in the cycle of the first push into an empty FIFO.
- Pop occurs on out_valid & out_ready.
- Push and pop in the same cycle with the FIFO full: both occur, the count is unchanged and nothing is dropped.
- Push with the FIFO full and no pop: the event is dropped and overflow=1. Held/FSM state still update, and overflow stays set until reset.
- Config write (cfg_we, cfg_idx < N_KEYS): table updates at the clock edge and takes effect from the next cycle. held[cfg_idx] is cleared. If cfg_idx==last_key, the FSM goes to IDLE. No release event is pushed. Writes with cfg_idx >= N_KEYS are ignored.
- Config write and ev_valid in the same cycle: lookup uses the old table contents.
- Pointer wrap-around: read/write pointers use modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer bit or an occupancy count.

Test Plan:
Use REPEAT_DELAY=10, REPEAT_PERIOD=4, FIFO_DEPTH=4, out_ready=1 unless stated.
1. After reset, press 9'h01C then release 9'h01C -> {press,2} then {release,2}, each seen one cycle after its strobe. key_held[2] is 1 between the two events.
2. Press 9'h023 and hold with rep_en=1 -> {press,3}, then {repeat,3} 10 cycles after the press, then every 4 cycles. Release -> {release,3} and no further repeats.
3. Send an unmapped code 9'h015, a duplicate press of 9'h01D while held, and a release of an unheld key -> no FIFO pushes and key_held unchanged.
4. With out_ready=0, five distinct presses (entries 0..3 plus a cfg-loaded entry 5=9'h124) -> four events queued, the fifth dropped, overflow=1. Raise out_ready -> events drain in order 0,1,2,3 and overflow stays 1.
5. Write cfg_idx=1, cfg_code=9'h02B while S is held -> key_held[1]=0 and no release pushed. Then 9'h02B maps to 1 and 9'h01B is ignored.
6. Assert rst mid-repeat with 3 queued events -> out_valid=0, key_held=0, overflow=0 and map restored next cycle. Then 9'h01D -> {press,0}.

Source files
------------

// File: rtl/key_event_encoder.sv
// Scan-code to key-number encoder with held tracking, auto-repeat and an event FIFO.
// The map table is runtime-loadable; events leave through a valid/ready handshake.
module key_event_encoder #(
   parameter int unsigned N_KEYS        = 8,
   parameter int unsigned NUM_W         = 3,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned REPEAT_DELAY  = 25000000,
   parameter int unsigned REPEAT_PERIOD = 5000000,
   parameter int unsigned CNT_W         = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ev_valid,
   input  logic [8:0]        ev_code,
   input  logic              ev_release,
   input  logic              rep_en,
   input  logic              cfg_we,
   input  logic [NUM_W-1:0]  cfg_idx,
   input  logic [8:0]        cfg_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_kind,
   output logic [NUM_W-1:0]  out_num,
   output logic [N_KEYS-1:0] key_held,
   output logic              overflow
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] KindPress   = 2'd0;
   localparam logic [1:0] KindRelease = 2'd1;
   localparam logic [1:0] KindRepeat  = 2'd2;

   typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

   function automatic logic [8:0] default_code(int unsigned i);
      case (i)
         0:       return 9'h01D;
         1:       return 9'h01B;
         2:       return 9'h01C;
         3:       return 9'h023;
         default: return 9'h000;
      endcase
   endfunction

   logic [8:0]        map_q [N_KEYS];
   logic [8:0]        map_d [N_KEYS];
   logic [N_KEYS-1:0] held_q, held_d;
   logic [NUM_W-1:0]  last_q, last_d;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [PtrW:0]     wr_q, wr_d, rd_q, rd_d;
   logic [NUM_W+1:0]  mem_q [FIFO_DEPTH];

   logic              hit;
   logic [NUM_W-1:0]  hit_idx;
   logic              push;
   logic [1:0]        push_kind;
   logic [NUM_W-1:0]  push_num;
   logic              fifo_empty, fifo_full, pop, fifo_we;

   // Walk downward so the lowest matching index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
         if (map_q[i] == ev_code && map_q[i] != 9'h000) begin
            hit     = 1'b1;
            hit_idx = NUM_W'(i);
         end
      end
   end

   always_comb begin
      map_d     = map_q;
      held_d    = held_q;
      last_d    = last_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_kind = KindPress;
      push_num  = '0;

      if (rep_en) begin
         case (state_q)
            StDelay: begin
               if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                  push      = 1'b1;
                  push_kind = KindRepeat;
                  push_num  = last_q;
                  state_d   = StRepeat;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StRepeat: begin
               if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                  push      = 1'b1;
                  push_kind = KindRepeat;
                  push_num  = last_q;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: cnt_d = '0;
         endcase
      end

      // An accepted key event overrides any repeat expiring in the same cycle.
      if (ev_valid && hit) begin
         if (!ev_release && !held_q[hit_idx]) begin
            held_d[hit_idx] = 1'b1;
            push            = 1'b1;
            push_kind       = KindPress;
            push_num        = hit_idx;
            last_d          = hit_idx;
            state_d         = rep_en ? StDelay : StIdle;
            cnt_d           = '0;
         end else if (ev_release && held_q[hit_idx]) begin
            held_d[hit_idx] = 1'b0;
            push            = 1'b1;
            push_kind       = KindRelease;
            push_num        = hit_idx;
            if (hit_idx == last_q) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
      end

      if (!rep_en) begin
         state_d = StIdle;
         cnt_d   = '0;
      end

      if (cfg_we && 32'(cfg_idx) < N_KEYS) begin
         map_d[cfg_idx]  = cfg_code;
         held_d[cfg_idx] = 1'b0;
         if (cfg_idx == last_q) begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      end
   end

   assign fifo_empty = (wr_q == rd_q);
   assign fifo_full  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
   assign pop        = !fifo_empty && out_ready;
   assign fifo_we    = push && (!fifo_full || pop);

   always_comb begin
      wr_d  = fifo_we ? wr_q + 1'b1 : wr_q;
      rd_d  = pop ? rd_q + 1'b1 : rd_q;
      ovf_d = ovf_q | (push && fifo_full && !pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_KEYS; i++) map_q[i] <= default_code(i);
         held_q  <= '0;
         last_q  <= '0;
         state_q <= StIdle;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         map_q   <= map_d;
         held_q  <= held_d;
         last_q  <= last_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_we) mem_q[wr_q[PtrW-1:0]] <= {push_kind, push_num};
   end

   assign out_valid             = !fifo_empty;
   assign {out_kind, out_num}   = fifo_empty ? '0 : mem_q[rd_q[PtrW-1:0]];
   assign key_held              = held_q;
   assign overflow              = ovf_q;

endmodule
